otter_alu_pipe: RTL and testbench
=================================

OTTER_ALU_PIPE -- requirements
Module: otter_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL derive SHAMT_W = $clog2(WIDTH) and not expose it as an overridable parameter.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FLUSH  input  1  synchronous abort of the in-flight operation.
REQ-006 SHALL have port IN_VALID  input  1  operands and function are valid.
REQ-007 SHALL have port IN_READY  output  1  block accepts an operation this cycle.
REQ-008 SHALL have ports ALU_A and ALU_B  input  WIDTH  operands.
REQ-009 SHALL have port ALU_FUN  input  4  operation code.
REQ-010 SHALL have port OUT_VALID  output  1  result registers hold a valid result.
REQ-011 SHALL have port OUT_READY  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port ALU_RESULT  output  WIDTH  registered result.
REQ-013 SHALL have port ZERO  output  1  registered; ALU_RESULT == 0.
REQ-014 SHALL have port ILLEGAL  output  1  registered; result came from an undefined ALU_FUN.

Function
REQ-015 SHALL decode ALU_FUN as follows: 0000 ADD; 1000 SUB; 0001 SLL; 0010 SLT; 0011 SLTU; 0100 XOR; 0101 SRL; 1101 SRA; 0110 OR; 0111 AND; 1001 COPY_A.
REQ-016 SHALL use only ALU_B[SHAMT_W-1:0] as the shift amount; ADD/SUB wrap modulo 2^WIDTH; SLT/SLTU produce zero-extended 0 or 1.
REQ-017 SHALL, for an undefined code, produce ALU_RESULT = all ones and ILLEGAL = 1, with the normal handshake and 1-cycle latency.
REQ-018 SHALL accept an operation when IN_VALID && IN_READY are both high at a rising edge.
REQ-019 SHALL implement the FSM IDLE -> BUSY (multi-cycle ops only) -> DONE; single-cycle ops go IDLE -> DONE.
REQ-020 SHALL present the result of a single-cycle op with OUT_VALID high on the cycle after acceptance.
REQ-021 SHALL drive IN_READY = !FLUSH && (state == IDLE || (state == DONE && OUT_READY)), giving one result per cycle under continuous OUT_READY.
REQ-022 SHALL hold ALU_RESULT, ZERO and ILLEGAL stable while OUT_VALID && !OUT_READY.
REQ-023 SHALL, in DONE with OUT_READY high and no new acceptance, return to IDLE and drop OUT_VALID on the next cycle.
REQ-024 SHALL, on FLUSH, enter IDLE on the next edge and deassert OUT_VALID; FLUSH overrides a simultaneous IN_VALID, which is not accepted.
REQ-025 SHALL ignore ALU_A, ALU_B and ALU_FUN when no acceptance occurs.

Reset
REQ-026 SHALL, while RST_N is low, force state = IDLE, OUT_VALID = 0, ALU_RESULT = 0, ZERO = 1, ILLEGAL = 0, and clear multiplier state.
REQ-027 SHALL abandon any operation in progress when RST_N asserts mid-operation, with no result emitted after release.
REQ-028 SHALL drive IN_READY = 1 on the first edge after RST_N deasserts.

Configuration
REQ-029 SHALL, when macro OTTER_ALU_MUL_EN is defined, add 1010 MUL (low WIDTH bits of unsigned A*B) and 1011 MULHU (high WIDTH bits).
REQ-030 SHALL compute MUL/MULHU by iterative shift-add, one bit per cycle: WIDTH cycles in BUSY, with OUT_VALID asserted on cycle WIDTH+1 after acceptance; IN_READY is low in BUSY.
REQ-031 SHALL, when OTTER_ALU_MUL_EN is undefined, treat 1010/1011 as undefined codes (REQ-017), with no BUSY state or multiplier registers synthesised.

Structure
REQ-032 SHALL place the ALU_FUN enum (4-bit typedef), the FSM state enum and the ILLEGAL_RESULT fill constant in package otter_alu_pkg.
REQ-033 SHALL implement the combinational single-cycle datapath as sub-module otter_alu_core (WIDTH-parametrised); the FSM, handshake and multiplier reside in otter_alu_pipe.

Verification
REQ-034 SHALL check: WIDTH=32, ADD 0xFFFFFFFF+1, OUT_READY=1 -> next cycle OUT_VALID=1, ALU_RESULT=0, ZERO=1.
REQ-035 SHALL check: SRA A=0x80000000 B=0x24 -> 0xF8000000 (shift 4); SLT A=0xFFFFFFFF B=1 -> 1; SLTU with the same operands -> 0.
REQ-036 SHALL check backpressure: SUB 5-7 with OUT_READY=0 for 3 cycles -> 0xFFFFFFFE held, IN_READY=0; OUT_READY=1 -> next op accepted the same cycle.
REQ-037 SHALL check: ALU_FUN=1111 -> ALU_RESULT=0xFFFFFFFF, ILLEGAL=1; FLUSH while IN_VALID=1 -> not accepted, OUT_VALID=0 next cycle.
REQ-038 SHALL check, with OTTER_ALU_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles; RST_N low at cycle 10 -> no output, IN_READY=1 after release.

Source files
------------

// File: rtl/otter_alu_pkg.sv
// Shared types and constants for the OTTER pipelined ALU.
// The optional multiplier is enabled by defining OTTER_ALU_MUL_EN.
package otter_alu_pkg;

  typedef enum logic [3:0] {
    FUN_ADD    = 4'b0000,
    FUN_SLL    = 4'b0001,
    FUN_SLT    = 4'b0010,
    FUN_SLTU   = 4'b0011,
    FUN_XOR    = 4'b0100,
    FUN_SRL    = 4'b0101,
    FUN_OR     = 4'b0110,
    FUN_AND    = 4'b0111,
    FUN_SUB    = 4'b1000,
    FUN_COPY_A = 4'b1001,
    FUN_MUL    = 4'b1010,
    FUN_MULHU  = 4'b1011,
    FUN_SRA    = 4'b1101
  } alu_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Replicated across the result width for undefined function codes.
  localparam logic ILLEGAL_RESULT = 1'b1;

endpackage

// File: rtl/otter_alu_core.sv
// Combinational single-cycle ALU datapath; multiply codes are reported
// illegal here and overridden by the pipeline when the multiplier exists.
module otter_alu_core
  import otter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fun,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt_s;

  assign shamt_s = b[SHAMT_W-1:0];

  // Function decode and result selection.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (fun)
      FUN_ADD:    result = a + b;
      FUN_SUB:    result = a - b;
      FUN_SLL:    result = a << shamt_s;
      FUN_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      FUN_SLTU:   result = {{(WIDTH-1){1'b0}}, (a < b)};
      FUN_XOR:    result = a ^ b;
      FUN_SRL:    result = a >> shamt_s;
      FUN_SRA:    result = $unsigned($signed(a) >>> shamt_s);
      FUN_OR:     result = a | b;
      FUN_AND:    result = a & b;
      FUN_COPY_A: result = a;
      default: begin
        result  = {WIDTH{ILLEGAL_RESULT}};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/otter_alu_pipe.sv
// Handshaked ALU with registered result and IDLE/BUSY/DONE control.
// Define OTTER_ALU_MUL_EN to add the iterative shift-add MUL/MULHU unit.
module otter_alu_pipe
  import otter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] ALU_A,
  input  logic [WIDTH-1:0] ALU_B,
  input  logic [3:0]       ALU_FUN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_RESULT,
  output logic             ZERO,
  output logic             ILLEGAL
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_r, state_next_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_last_s;
  logic [WIDTH-1:0] mul_result_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_illegal_s;
  logic             load_s;
  logic [WIDTH-1:0] load_result_s;
  logic             load_illegal_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             illegal_r;

  otter_alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (ALU_A),
    .b       (ALU_B),
    .fun     (ALU_FUN),
    .result  (core_result_s),
    .illegal (core_illegal_s)
  );

  assign IN_READY   = !FLUSH && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && OUT_READY));
  assign accept_s   = IN_VALID && IN_READY;
  assign OUT_VALID  = out_valid_r;
  assign ALU_RESULT = result_r;
  assign ZERO       = zero_r;
  assign ILLEGAL    = illegal_r;

`ifdef OTTER_ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] prod_next_s;
  logic [WIDTH:0]     psum_s;
  logic [SHAMT_W-1:0] cnt_r;
  logic               hi_r;

  assign is_mul_s     = (ALU_FUN == FUN_MUL) || (ALU_FUN == FUN_MULHU);
  // Multiplier sits in the low half and is consumed LSB first.
  assign psum_s       = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mcand_r} : '0);
  assign prod_next_s  = {psum_s, prod_r[WIDTH-1:1]};
  assign mul_last_s   = (state_r == ST_BUSY) && (cnt_r == SHAMT_W'(WIDTH - 1));
  assign mul_result_s = hi_r ? prod_next_s[2*WIDTH-1:WIDTH] : prod_next_s[WIDTH-1:0];

  // Shift-add multiplier state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand_r <= '0;
      prod_r  <= '0;
      cnt_r   <= '0;
      hi_r    <= 1'b0;
    end else if (accept_s && is_mul_s) begin
      mcand_r <= ALU_A;
      prod_r  <= {{WIDTH{1'b0}}, ALU_B};
      cnt_r   <= '0;
      hi_r    <= (ALU_FUN == FUN_MULHU);
    end else if (state_r == ST_BUSY) begin
      prod_r  <= prod_next_s;
      cnt_r   <= cnt_r + 1'b1;
    end
  end
`else
  assign is_mul_s     = 1'b0;
  assign mul_last_s   = 1'b0;
  assign mul_result_s = '0;
`endif

  // Next-state and result-load decode.
  always_comb begin
    state_next_s   = state_r;
    load_s         = 1'b0;
    load_result_s  = core_result_s;
    load_illegal_s = core_illegal_s;
    if (FLUSH) begin
      state_next_s = ST_IDLE;
    end else if (accept_s) begin
      if (is_mul_s) begin
        state_next_s = ST_BUSY;
      end else begin
        state_next_s = ST_DONE;
        load_s       = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_BUSY: begin
          if (mul_last_s) begin
            state_next_s   = ST_DONE;
            load_s         = 1'b1;
            load_result_s  = mul_result_s;
            load_illegal_s = 1'b0;
          end else begin
            state_next_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DONE;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, valid flag and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b1;
      illegal_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == ST_DONE);
      if (load_s) begin
        result_r  <= load_result_s;
        zero_r    <= (load_result_s == '0);
        illegal_r <= load_illegal_s;
      end
    end
  end

endmodule

// File: tb/tb_otter_alu_pipe.sv
// Randomised self-checking bench for otter_alu_pipe (WIDTH=32), with a
// plain-arithmetic reference; multiplier cases run when OTTER_ALU_MUL_EN is defined.
module tb_otter_alu_pipe;

  logic        CLK = 1'b0;
  logic        RST_N, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, ZERO, ILLEGAL;
  logic [31:0] ALU_A, ALU_B, ALU_RESULT;
  logic [3:0]  ALU_FUN;

  int err_cnt = 0;
  int chk_cnt = 0;

  otter_alu_pipe #(.WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ALU_RESULT(ALU_RESULT), .ZERO(ZERO), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    int s;
    s   = int'(b[4:0]);
    p   = {32'd0, a} * {32'd0, b};
    ill = 1'b0;
    lat = 1;
    case (f)
      4'h0: r = a + b;
      4'h8: r = a - b;
      4'h1: r = a << s;
      4'h2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'h3: r = (a < b) ? 32'd1 : 32'd0;
      4'h4: r = a ^ b;
      4'h5: r = a >> s;
      4'hD: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'h6: r = a | b;
      4'h7: r = a & b;
      4'h9: r = a;
`ifdef OTTER_ALU_MUL_EN
      4'hA: begin r = p[31:0];  lat = 33; end
      4'hB: begin r = p[63:32]; lat = 33; end
`endif
      default: begin r = 32'hFFFF_FFFF; ill = 1'b1; end
    endcase
  endfunction

  // One complete transaction from idle: accept, wait, optional stall, drain.
  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          n;
    ref_alu(f, a, b, er, ei, el);
    @(negedge CLK);
    ALU_FUN = f; ALU_A = a; ALU_B = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1 check_value("in_ready_idle", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 1'b0; ALU_A = $urandom; ALU_B = $urandom; ALU_FUN = 4'($urandom);
    OUT_READY = (stall == 0);
    n = 1;
    while (!OUT_VALID && n < 60) begin
      if (n == 2) check_value("in_ready_busy", IN_READY, 0);
      @(negedge CLK);
      n++;
    end
    check_value("latency", n, el);
    check_value("result", ALU_RESULT, er);
    check_value("illegal", ILLEGAL, ei);
    check_value("zero", ZERO, er == 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      check_value("stall_valid", OUT_VALID, 1);
      check_value("stall_result", ALU_RESULT, er);
      if (i == stall - 1) OUT_READY = 1'b1;
    end
    @(negedge CLK);
    check_value("drain_valid", OUT_VALID, 0);
  endtask

  initial begin
    logic [31:0] q_res[$];
    logic [31:0] er, ra, rb;
    logic        ei;
    logic [3:0]  rf;
    int          el;
    logic        seen;

    RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    ALU_A = 32'd0; ALU_B = 32'd0; ALU_FUN = 4'd0;
    repeat (2) @(negedge CLK);
    check_value("rst_out_valid", OUT_VALID, 0);
    check_value("rst_result", ALU_RESULT, 0);
    check_value("rst_zero", ZERO, 1);
    check_value("rst_illegal", ILLEGAL, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check_value("rst_in_ready", IN_READY, 1);

    do_op(4'h0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'hD, 32'h8000_0000, 32'h24, 0);
    do_op(4'h2, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'h3, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'hF, 32'h1234_5678, 32'h9, 1);
    do_op(4'hA, 32'h7, 32'h9, 0);

    // Backpressure: held result, IN_READY low, then same-cycle acceptance.
    @(negedge CLK);
    ALU_FUN = 4'h8; ALU_A = 32'd5; ALU_B = 32'd7; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    ALU_FUN = 4'h0; ALU_A = 32'd3; ALU_B = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1 check_value("bp_in_ready", IN_READY, 0);
      check_value("bp_valid", OUT_VALID, 1);
      check_value("bp_result", ALU_RESULT, 32'hFFFF_FFFE);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #1 check_value("bp_release_ready", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    check_value("bp_next_valid", OUT_VALID, 1);
    check_value("bp_next_result", ALU_RESULT, 32'd7);
    @(negedge CLK);
    check_value("bp_drain", OUT_VALID, 0);

    // FLUSH overrides IN_VALID.
    FLUSH = 1'b1; IN_VALID = 1'b1; ALU_FUN = 4'h0;
    #1 check_value("flush_in_ready", IN_READY, 0);
    @(negedge CLK);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check_value("flush_no_accept", OUT_VALID, 0);
    @(negedge CLK);
    check_value("flush_still_idle", OUT_VALID, 0);

    // FLUSH drops a pending result.
    ALU_FUN = 4'h6; ALU_A = 32'h1; ALU_B = 32'h2; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check_value("flush_pend_valid", OUT_VALID, 1);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0; OUT_READY = 1'b1;
    check_value("flush_done_drop", OUT_VALID, 0);

    // Continuous stream: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        check_value("stream_valid", OUT_VALID, 1);
        check_value("stream_result", ALU_RESULT, q_res.pop_front());
      end
      do begin rf = 4'($urandom); end while (rf == 4'hA || rf == 4'hB);
      ra = $urandom; rb = $urandom;
      ref_alu(rf, ra, rb, er, ei, el);
      q_res.push_back(er);
      ALU_FUN = rf; ALU_A = ra; ALU_B = rb; IN_VALID = 1'b1;
      #1 check_value("stream_ready", IN_READY, 1);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    check_value("stream_last", ALU_RESULT, q_res.pop_front());
    @(negedge CLK);

`ifdef OTTER_ALU_MUL_EN
    do_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    // Reset mid-multiply: nothing may emerge afterwards.
    @(negedge CLK);
    ALU_FUN = 4'hB; ALU_A = 32'hFFFF_FFFF; ALU_B = 32'hFFFF_FFFF; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    #1 check_value("mrst_valid", OUT_VALID, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_value("mrst_in_ready", IN_READY, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen = seen | OUT_VALID;
    end
    check_value("mrst_no_output", seen, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      rf = 4'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      do_op(rf, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
